// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a small instruction memory, then fetches and
// issues words one at a time with a fixed execute hold, stopping on HALT or end of memory.
module instr_sequencer #(
  parameter int unsigned IMEM_DEPTH  = 64,
  parameter int unsigned EXEC_CYCLES = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [31:0]                   instrword,
  output logic                          newinstr,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          done
);
  localparam int unsigned   AW        = $clog2(IMEM_DEPTH);
  localparam logic [31:0]   HALT_WORD = 32'hFC00_0000;
  localparam logic [AW-1:0] LAST_PC   = AW'(IMEM_DEPTH - 1);
  localparam logic [3:0]    WAIT_INIT = 4'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t      r_state;
  logic [3:0]  r_count;
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] w_fetch_word;
  logic        w_load_ok;

  assign w_fetch_word = r_imem[pc];
  assign w_load_ok    = load_en && !reset && (r_state == S_IDLE || r_state == S_HALTED);

  // Memory has no reset so a program survives a mid-run abort.
  always_ff @(posedge clock) begin
    if (w_load_ok) begin
      r_imem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      pc        <= '0;
      instrword <= '0;
      newinstr  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      newinstr <= 1'b0;
      case (r_state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            r_state <= S_FETCH;
            pc      <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        S_FETCH: begin
          if (w_fetch_word == HALT_WORD) begin
            r_state <= S_HALTED;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            instrword <= w_fetch_word;
            newinstr  <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_count <= WAIT_INIT;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else if (pc == LAST_PC) begin
            r_state <= S_HALTED;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            pc      <= pc + AW'(1);
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table, hand sequences and
// randomized programs compared against an issue-schedule model.
module tb_instr_sequencer;
  localparam int          DEPTH = 64;
  localparam int          EXEC  = 6;
  localparam int          P     = EXEC + 2;
  localparam int          P1    = 3;
  localparam logic [31:0] HALT  = 32'hFC00_0000;
  localparam logic [31:0] D0    = 32'h0022_1820;
  localparam logic [31:0] D1    = 32'h8C44_0004;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] instrword;
  logic        newinstr, busy, done;
  logic [5:0]  pc;

  logic        reset1, start1, load_en1;
  logic [2:0]  load_addr1;
  logic [31:0] load_data1;
  logic [31:0] instrword1;
  logic        newinstr1, busy1, done1;
  logic [2:0]  pc1;

  instr_sequencer #(.IMEM_DEPTH(64), .EXEC_CYCLES(6)) dut (
    .clock(clock), .reset(reset), .start(start), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .instrword(instrword),
    .newinstr(newinstr), .pc(pc), .busy(busy), .done(done)
  );

  instr_sequencer #(.IMEM_DEPTH(8), .EXEC_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset1), .start(start1), .load_en(load_en1),
    .load_addr(load_addr1), .load_data(load_data1), .instrword(instrword1),
    .newinstr(newinstr1), .pc(pc1), .busy(busy1), .done(done1)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] last_word;

  typedef struct {
    logic        rst, st, ld;
    logic [5:0]  addr;
    logic [31:0] data;
    int          ncyc;
    logic        e_busy, e_done, e_new;
    logic [5:0]  e_pc;
    logic [31:0] e_word;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    cyc();
    load_en = 1'b0;
    mem[a] = d;
  endtask

  // Expected behaviour from the program alone: word j issues at cycle 1+j*P,
  // a HALT at word j stops at 1+j*P, running off the end stops at DEPTH*P.
  task automatic run_prog(input bit with_load, input logic [5:0] la, input logic [31:0] ld,
                          input bit noise, input string tag);
    logic [31:0] words [DEPTH];
    int          exp_n, halt_cyc, halt_pc, k, exp_pc;
    bit          exp_new;
    logic [31:0] ew;
    if (with_load) mem[la] = ld;
    exp_n = 0; halt_cyc = DEPTH * P; halt_pc = DEPTH - 1;
    for (int j = 0; j < DEPTH; j++) begin
      if (mem[j] == HALT) begin
        halt_cyc = 1 + j * P; halt_pc = j;
        break;
      end
      words[exp_n] = mem[j];
      exp_n++;
    end
    start = 1'b1; load_en = with_load; load_addr = la; load_data = ld;
    cyc();
    start = 1'b0; load_en = 1'b0;
    for (int c = 0; c <= halt_cyc + 2; c++) begin
      k = (c >= 1) ? (c - 1) / P : 0;
      exp_new = (c >= 1) && ((c - 1) % P == 0) && (k < exp_n);
      if (c >= 1 && exp_n > 0) ew = words[(k < exp_n) ? k : exp_n - 1];
      else ew = last_word;
      exp_pc = (c / P < halt_pc) ? c / P : halt_pc;
      chk($sformatf("%s newinstr c=%0d", tag, c), 32'(newinstr), 32'(exp_new));
      chk($sformatf("%s instrword c=%0d", tag, c), instrword, ew);
      chk($sformatf("%s pc c=%0d", tag, c), 32'(pc), 32'(exp_pc));
      chk($sformatf("%s done c=%0d", tag, c), 32'(done), 32'(c >= halt_cyc));
      chk($sformatf("%s busy c=%0d", tag, c), 32'(busy), 32'(c < halt_cyc));
      if (noise && c < halt_cyc) begin
        start = 1'($urandom); load_en = 1'($urandom);
        load_addr = 6'($urandom); load_data = $urandom;
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
      if (c < halt_cyc + 2) cyc();
    end
    start = 1'b0; load_en = 1'b0;
    if (exp_n > 0) last_word = words[exp_n - 1];
  endtask

  initial begin
    int pulses;
    logic [31:0] w;
    logic [31:0] e1w;
    reset = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    reset1 = 1'b1; start1 = 1'b0; load_en1 = 1'b0; load_addr1 = '0; load_data1 = '0;

    //          rst   st    ld    addr   data        n   busy  done  new   pc     word
    vt[0]  = '{1'b1, 1'b0, 1'b0, 6'd0, 32'h0,       1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 6'd0, D0,          1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 6'd1, D1,          1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 6'd2, HALT,        1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 6'd0, 32'h0,       1, 1'b1, 1'b0, 1'b0, 6'd0, 32'h0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,       1, 1'b1, 1'b0, 1'b1, 6'd0, D0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,       1, 1'b1, 1'b0, 1'b0, 6'd0, D0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,       7, 1'b1, 1'b0, 1'b1, 6'd1, D1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,       8, 1'b0, 1'b1, 1'b0, 6'd2, D1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 6'd0, 32'h0,       1, 1'b1, 1'b0, 1'b0, 6'd0, D1};
    vt[10] = '{1'b0, 1'b0, 1'b0, 6'd0, 32'h0,       1, 1'b1, 1'b0, 1'b1, 6'd0, D0};
    vt[11] = '{1'b1, 1'b1, 1'b1, 6'd0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vt[12] = '{1'b1, 1'b0, 1'b1, 6'd0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 6'd0, 32'h0,       1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0};

    @(negedge clock);
    for (int i = 0; i < 14; i++) begin
      reset = vt[i].rst; start = vt[i].st; load_en = vt[i].ld;
      load_addr = vt[i].addr; load_data = vt[i].data;
      cyc();
      reset = 1'b0; start = 1'b0; load_en = 1'b0;
      for (int n = 1; n < vt[i].ncyc; n++) cyc();
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vt[i].e_busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(vt[i].e_done));
      chk($sformatf("vec%0d newinstr", i), 32'(newinstr), 32'(vt[i].e_new));
      chk($sformatf("vec%0d pc", i), 32'(pc), 32'(vt[i].e_pc));
      chk($sformatf("vec%0d instrword", i), instrword, vt[i].e_word);
    end
    for (int j = 0; j < DEPTH; j++) mem[j] = 32'h0;
    mem[0] = D0; mem[1] = D1; mem[2] = HALT;
    last_word = 32'h0;

    // Reset three cycles into the second instruction's WAIT.
    start = 1'b1; cyc(); start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (newinstr) pulses++;
    end
    chk("abort pulses before reset", 32'(pulses), 32'd2);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort newinstr", 32'(newinstr), 32'd0);
    chk("abort pc", 32'(pc), 32'd0);
    chk("abort instrword", instrword, 32'h0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (newinstr || busy) pulses++;
    end
    chk("abort quiet cycles", 32'(pulses), 32'd0);
    run_prog(1'b0, 6'd0, 32'h0, 1'b0, "restart");

    reset = 1'b1; cyc(); reset = 1'b0;
    last_word = 32'h0;
    run_prog(1'b1, 6'd0, 32'h0085_1022, 1'b0, "ld_start");
    run_prog(1'b0, 6'd0, 32'h0, 1'b1, "busy_noise");
    run_prog(1'b0, 6'd0, 32'h0, 1'b0, "after_noise");

    for (int j = 0; j < DEPTH; j++) load(6'(j), 32'h0000_0020);
    run_prog(1'b0, 6'd0, 32'h0, 1'b0, "full");

    for (int it = 0; it < 3; it++) begin
      for (int j = 0; j < DEPTH; j++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        load(6'(j), w);
      end
      if (it != 1) load(6'($urandom_range(3, 63)), HALT);
      run_prog(1'b0, 6'd0, 32'h0, 1'b1, $sformatf("rand%0d", it));
    end

    // EXEC_CYCLES=1 instance: pulses every 3 cycles, word held in between.
    reset1 = 1'b1; cyc(); reset1 = 1'b0;
    load_en1 = 1'b1;
    load_addr1 = 3'd0; load_data1 = D0; cyc();
    load_addr1 = 3'd1; load_data1 = D1; cyc();
    load_addr1 = 3'd2; load_data1 = HALT; cyc();
    load_en1 = 1'b0;
    start1 = 1'b1; cyc(); start1 = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      e1w = (c == 0) ? 32'h0 : ((c < 4) ? D0 : D1);
      chk($sformatf("e1 newinstr c=%0d", c), 32'(newinstr1),
          32'((c >= 1) && ((c - 1) % P1 == 0) && ((c - 1) / P1 < 2)));
      chk($sformatf("e1 instrword c=%0d", c), instrword1, e1w);
      chk($sformatf("e1 pc c=%0d", c), 32'(pc1), 32'((c / P1 < 2) ? c / P1 : 2));
      chk($sformatf("e1 done c=%0d", c), 32'(done1), 32'(c >= 7));
      chk($sformatf("e1 busy c=%0d", c), 32'(busy1), 32'(c < 7));
      if (c < 9) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
